l2_responder: RTL and testbench
===============================

// Module: l2_responder
// PURPOSE
//  L2-side responder for the coherence block's L2 request interface.
//  - Services the merged L1A/L1B read/write traffic forwarded by the coherence block.
//  - Holds a word-addressed backing store and applies a configurable access latency.
//  - Drives L2_busy back to the coherence block, which fans it out to the L1s.
// PARAMETERS
//  n         32  data word width
//  ADDR_W    15  word address width (5 tag + 6 index + 4 offset, as in the L1s)
//  RD_LAT     3  busy cycles for a read, 1..15
//  WR_LAT     2  busy cycles for a write, 1..15
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       asynchronous, active-high reset
//  L2_read_request   in   1       level read request from the coherence block
//  L2_write_request  in   1       level write request from the coherence block
//  L2_word_address   in   ADDR_W  word address of the access
//  L2_rdata          in   n       data to store (L1 -> L2)
//  L2_busy           out  1       access in progress; to the coherence L2_busy_in
//  L2_wdata          out  n       read data (L2 -> L1)
//  rd_count          out  16      [L2_STATS_EN only] completed reads
//  wr_count          out  16      [L2_STATS_EN only] completed writes
// BEHAVIOUR
//  Reset values:
//   - L2_busy=0, L2_wdata=0, state=IDLE, counters=0.
//   - Backing store is NOT cleared.
//  FSM states: IDLE, WRITE, READ, RELEASE.
//  IDLE:
//   - On a clk edge with any request high, capture L2_word_address and L2_rdata.
//   - write_request high -> WRITE; else read_request high -> READ.
//   - L2_busy=1 from the cycle after acceptance.
//  WRITE:
//   - Latency counter loads WR_LAT-1.
//   - On the final cycle, mem[addr] <= captured data.
//   - If read_request was also high at acceptance: -> READ, L2_busy stays 1, same address.
//   - Otherwise -> RELEASE.
//  READ:
//   - Counter loads RD_LAT-1.
//   - On the final cycle, L2_wdata <= mem[addr], which already includes a write done earlier in the same transaction.
//   - Then -> RELEASE.
//  RELEASE:
//   - L2_busy=0.
//   - Stay until both requests are low; requests still held from the finished access are ignored.
//   - Then -> IDLE.
//   - A new access therefore needs the requests to drop for at least one edge.
//  Timing and data rules:
//   - Busy runs exactly LAT cycles per phase.
//   - Read+write transaction: busy runs WR_LAT+RD_LAT contiguous cycles.
//   - L2_wdata holds its value until the next read completes.
//   - Address and data are sampled only at acceptance; later input changes have no effect.
//   - A request dropped mid-access does not abort it.
//   - Reset mid-access: immediate abort, busy=0, any pending write is NOT committed.
//   - Address covers the full 2**ADDR_W words; no wrap or out-of-range case.
// CONFIGURATION
//  L2_STATS_EN defined:
//   - Adds rd_count and wr_count outputs.
//   - Each increments on its phase's final cycle and saturates at 16'hFFFF.
//   - Both clear on reset.
//  L2_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  l2_pkg:
//   - ADDR_W_DEF=15 and the L2_TAG_W/L2_INDEX_W/L2_OFFSET_W split (5/6/4).
//   - typedef enum logic [1:0] l2_state_t {IDLE,WRITE,READ,RELEASE}.
//   - LAT_W=4.
//  Sub-module l2_lat_counter:
//   - load/value in, done out.
//   - Down-counter that flags the final busy cycle; one instance, reused per phase.
// TESTING
//  1. Reset mid-read (RD_LAT=3): reset in the 2nd busy cycle -> busy=0 at once, L2_wdata=0, state IDLE.
//  2. Write addr 70, data 5, then drop: busy high 2 cycles -> RELEASE -> IDLE; then read 70 -> busy 3 cycles, L2_wdata=5.
//  3. Read and write both high, addr 70, data 9: busy 5 contiguous cycles, then L2_wdata=9 and mem[70]=9.
//  4. Hold read_request high for 10 cycles after completion: exactly one access, busy stays 0 in RELEASE.
//  5. Change address and data during busy: stored/read values use the captured addr/data only.
//  6. L2_STATS_EN: 3 writes + 2 reads -> wr_count=3, rd_count=2; force count 16'hFFFF, one more read -> stays 16'hFFFF.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 responder: state encoding, address split, latency width.
package l2_pkg;

  localparam int ADDR_W_DEF  = 15;
  localparam int L2_TAG_W    = 5;
  localparam int L2_INDEX_W  = 6;
  localparam int L2_OFFSET_W = 4;
  localparam int LAT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RELEASE
  } l2_state_t;

  // Word address viewed the same way the L1s split it.
  typedef struct packed {
    logic [L2_TAG_W-1:0]    tag;
    logic [L2_INDEX_W-1:0]  index;
    logic [L2_OFFSET_W-1:0] offset;
  } l2_addr_t;

endpackage

// File: rtl/l2_responder_if.sv
// L2 request/response bundle between the coherence block (master) and the L2 responder (slave).
interface l2_responder_if
  import l2_pkg::*;
#(
  parameter int n      = 32,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              L2_read_request;
  logic              L2_write_request;
  logic [ADDR_W-1:0] L2_word_address;
  logic [n-1:0]      L2_rdata;
  logic              L2_busy;
  logic [n-1:0]      L2_wdata;

  modport master (
    output L2_read_request,
    output L2_write_request,
    output L2_word_address,
    output L2_rdata,
    input  L2_busy,
    input  L2_wdata
  );

  modport slave (
    input  L2_read_request,
    input  L2_write_request,
    input  L2_word_address,
    input  L2_rdata,
    output L2_busy,
    output L2_wdata
  );

endinterface

// File: rtl/l2_lat_counter.sv
// Down-counter timing one access phase; done_o marks the phase's final busy cycle.
module l2_lat_counter
  import l2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [LAT_W-1:0] value_i,
  output logic             done_o
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/l2_responder.sv
// L2-side responder: word-addressed backing store with fixed read/write busy latencies.
// Optional L2_STATS_EN adds saturating completed-read/write counters (rd_count, wr_count).
module l2_responder
  import l2_pkg::*;
#(
  parameter int n      = 32,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 3,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef L2_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  l2_responder_if.slave l2
);

  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

  l2_state_t         state_q;
  logic              busy_q;
  logic [n-1:0]      wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [n-1:0]      data_q;
  logic              readAlso_q;
`ifdef L2_STATS_EN
  logic [15:0]       rdCnt_q;
  logic [15:0]       wrCnt_q;
`endif

  logic              anyReq;
  logic              latLoad;
  logic [LAT_W-1:0]  latValue;
  logic              latDone;
  logic              memWe;
  logic [n-1:0]      memRdata;

  logic [n-1:0]      mem [2**ADDR_W];

  assign anyReq = l2.L2_read_request | l2.L2_write_request;

  // The counter is armed at acceptance and again when a write hands over to its read.
  always_comb begin
    latLoad  = 1'b0;
    latValue = '0;
    if (state_q == IDLE && anyReq) begin
      latLoad  = 1'b1;
      latValue = l2.L2_write_request ? WR_LOAD : RD_LOAD;
    end else if (state_q == WRITE && latDone && readAlso_q) begin
      latLoad  = 1'b1;
      latValue = RD_LOAD;
    end
  end

  l2_lat_counter u_lat (
    .clk     (clk),
    .reset   (reset),
    .load_i  (latLoad),
    .value_i (latValue),
    .done_o  (latDone)
  );

  assign memWe    = (state_q == WRITE) && latDone;
  assign memRdata = mem[addr_q];

  // Backing store has no reset; an aborted write never reaches it because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      readAlso_q <= 1'b0;
`ifdef L2_STATS_EN
      rdCnt_q    <= '0;
      wrCnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            addr_q     <= l2.L2_word_address;
            data_q     <= l2.L2_rdata;
            readAlso_q <= l2.L2_write_request & l2.L2_read_request;
            busy_q     <= 1'b1;
            state_q    <= l2.L2_write_request ? WRITE : READ;
          end
        end
        WRITE: begin
          if (latDone) begin
`ifdef L2_STATS_EN
            if (wrCnt_q != 16'hFFFF) wrCnt_q <= wrCnt_q + 16'd1;
`endif
            if (readAlso_q) begin
              state_q <= READ;
            end else begin
              state_q <= RELEASE;
              busy_q  <= 1'b0;
            end
          end
        end
        READ: begin
          if (latDone) begin
`ifdef L2_STATS_EN
            if (rdCnt_q != 16'hFFFF) rdCnt_q <= rdCnt_q + 16'd1;
`endif
            wdata_q <= memRdata;
            state_q <= RELEASE;
            busy_q  <= 1'b0;
          end
        end
        RELEASE: begin
          // Requests still held from the finished access must drop before a new one is taken.
          if (!anyReq) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign l2.L2_busy  = busy_q;
  assign l2.L2_wdata = wdata_q;

`ifdef L2_STATS_EN
  assign rd_count = rdCnt_q;
  assign wr_count = wrCnt_q;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Randomized bench for l2_responder against a behavioural memory/latency model.
// Covers L2_STATS_EN counters when that macro is defined.
module tb_l2_responder;

  localparam int N      = 32;
  localparam int AW     = 15;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  l2_responder_if #(.n(N), .ADDR_W(AW)) bus ();

`ifdef L2_STATS_EN
  logic [15:0] rdCount;
  logic [15:0] wrCount;
`endif

  l2_responder #(.n(N), .ADDR_W(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef L2_STATS_EN
    .rd_count (rdCount),
    .wr_count (wrCount),
`endif
    .l2       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0]  refMem [int];
  logic [N-1:0]  expWdata = '0;
  int            expRd = 0;
  int            expWr = 0;
  int unsigned   writtenAddr [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full access: drive, scramble inputs while busy, measure busy length, check read data.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [AW-1:0] addr,
                               input logic [N-1:0] data, input bit dropEarly, input int holdAfter);
    int busyLen;
    bit sawLow;
    int expLen;
    expLen = (wr ? WR_LAT : 0) + (rd ? RD_LAT : 0);
    @(negedge clk);
    bus.L2_read_request  = rd;
    bus.L2_write_request = wr;
    bus.L2_word_address  = addr;
    bus.L2_rdata         = data;
    @(posedge clk);
    busyLen = 0;
    sawLow  = 1'b0;
    for (int c = 0; c < 40 && !sawLow; c++) begin
      @(negedge clk);
      if (bus.L2_busy === 1'b1) begin
        busyLen++;
        bus.L2_word_address = AW'($urandom);
        bus.L2_rdata        = $urandom;
        if (dropEarly) begin
          bus.L2_read_request  = 1'b0;
          bus.L2_write_request = 1'b0;
        end
      end else begin
        sawLow = 1'b1;
      end
    end
    if (wr) begin
      refMem[int'(addr)] = data;
      writtenAddr.push_back(int'(addr));
      expWr++;
    end
    if (rd) begin
      expWdata = refMem[int'(addr)];
      expRd++;
    end
    checkOutput("busyLen", busyLen, expLen);
    checkOutput("wdata", bus.L2_wdata, expWdata);
    for (int h = 0; h < holdAfter; h++) begin
      @(negedge clk);
      checkOutput("busyHeld", {31'b0, bus.L2_busy}, 32'd0);
    end
    bus.L2_read_request  = 1'b0;
    bus.L2_write_request = 1'b0;
    @(negedge clk);
  endtask

  task automatic resetMidRead(input logic [AW-1:0] addr);
    @(negedge clk);
    bus.L2_read_request = 1'b1;
    bus.L2_word_address = addr;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstPreBusy", {31'b0, bus.L2_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rstBusy", {31'b0, bus.L2_busy}, 32'd0);
    checkOutput("rstWdata", bus.L2_wdata, 32'd0);
    expWdata = '0;
    expRd    = 0;
    expWr    = 0;
    bus.L2_read_request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic resetMidWrite(input logic [AW-1:0] addr, input logic [N-1:0] data);
    @(negedge clk);
    bus.L2_write_request = 1'b1;
    bus.L2_word_address  = addr;
    bus.L2_rdata         = data;
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrAbortBusy", {31'b0, bus.L2_busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("wrAbortIdle", {31'b0, bus.L2_busy}, 32'd0);
    expWdata = '0;
    expRd    = 0;
    expWr    = 0;
    bus.L2_write_request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    int unsigned   op;
    reset                = 1'b1;
    bus.L2_read_request  = 1'b0;
    bus.L2_write_request = 1'b0;
    bus.L2_word_address  = '0;
    bus.L2_rdata         = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'b0, bus.L2_busy}, 32'd0);
    checkOutput("resetWdata", bus.L2_wdata, 32'd0);
    reset = 1'b0;

    applyStimulus(1'b0, 1'b1, AW'(70), 32'd5, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, AW'(70), 32'd0, 1'b1, 0);
    applyStimulus(1'b1, 1'b1, AW'(70), 32'd9, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, AW'(70), 32'd0, 1'b0, 10);

    applyStimulus(1'b0, 1'b1, AW'(0), 32'hA5A5_0001, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, AW'((1 << AW) - 1), 32'h5A5A_FFFF, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, AW'(0), 32'd0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, AW'((1 << AW) - 1), 32'd0, 1'b1, 0);

    resetMidRead(AW'(70));
    applyStimulus(1'b0, 1'b1, AW'(123), 32'h1111_2222, 1'b1, 0);
    resetMidWrite(AW'(123), 32'h3333_4444);
    applyStimulus(1'b1, 1'b0, AW'(123), 32'd0, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        applyStimulus(1'b0, 1'b1, AW'($urandom), $urandom, 1'($urandom), $urandom_range(0, 2));
      end else if (op == 1) begin
        a = AW'(writtenAddr[$urandom_range(0, writtenAddr.size() - 1)]);
        applyStimulus(1'b1, 1'b0, a, $urandom, 1'($urandom), $urandom_range(0, 2));
      end else begin
        applyStimulus(1'b1, 1'b1, AW'($urandom), $urandom, 1'($urandom), $urandom_range(0, 2));
      end
    end

`ifdef L2_STATS_EN
    checkOutput("rdCountRand", {16'b0, rdCount}, 32'(expRd));
    checkOutput("wrCountRand", {16'b0, wrCount}, 32'(expWr));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expRd = 0;
    expWr = 0;
    expWdata = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, AW'(200 + i), 32'(i + 40), 1'b1, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, AW'(200 + i), 32'd0, 1'b1, 0);
    checkOutput("rdCount", {16'b0, rdCount}, 32'd2);
    checkOutput("wrCount", {16'b0, wrCount}, 32'd3);
    @(negedge clk);
    force dut.rdCnt_q = 16'hFFFF;
    #1;
    release dut.rdCnt_q;
    applyStimulus(1'b1, 1'b0, AW'(200), 32'd0, 1'b1, 0);
    checkOutput("rdCountSat", {16'b0, rdCount}, 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
